// File: rtl/eth_udp_pkg.sv
// Shared definitions for the GMII UDP receiver: one-hot state encodings,
// header byte counts, default filter constants and the broadcast MAC.
package eth_udp_pkg;

  typedef enum logic [7:0] {
    IDLE          = 8'b0000_0001,
    RX_PREAMBLE   = 8'b0000_0010,
    RX_ETH_HEADER = 8'b0000_0100,
    RX_IP_HEADER  = 8'b0000_1000,
    RX_UDP_HEADER = 8'b0001_0000,
    RX_DATA       = 8'b0010_0000,
    RX_TAIL       = 8'b0100_0000,
    RX_DROP       = 8'b1000_0000
  } rx_state_t;

  localparam logic [15:0] ETH_HDR_BYTES = 16'd14;
  localparam logic [15:0] IP_HDR_BYTES  = 16'd20;
  localparam logic [15:0] UDP_HDR_BYTES = 16'd8;

  localparam logic [15:0] ETH_TYPE_DEFAULT = 16'h0800;
  localparam logic [7:0]  IP_PROTO_DEFAULT = 8'h11;
  localparam logic [47:0] BCAST_MAC        = 48'hFFFF_FFFF_FFFF;

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide Ethernet CRC-32 (reflected poly 0xEDB88320, init all ones).
// crc_result is the complemented register: transmitted FCS byte n equals
// crc_result[8n+7:8n].
module crc32_d8 (
  input  logic        clk,
  input  logic        reset_p,
  input  logic [7:0]  data,
  input  logic        crc_init,
  input  logic        crc_en,
  output logic [31:0] crc_result
);

  logic [31:0] r_crc;

  function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      c = (c >> 1) ^ (((c[0] ^ d[i]) == 1'b1) ? 32'hEDB8_8320 : 32'h0);
    end
    return c;
  endfunction

  // CRC register: reload on frame start, fold in one byte per enable.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p)       r_crc <= 32'hFFFF_FFFF;
    else if (crc_init) r_crc <= 32'hFFFF_FFFF;
    else if (crc_en)   r_crc <= crc_step(r_crc, data);
  end

  assign crc_result = ~r_crc;

endmodule

// File: rtl/eth_udp_rx_gmii.sv
// GMII Ethernet/IPv4/UDP receiver: filters on MAC/IP/port, streams payload
// bytes, reports sender fields and a done/err pulse per accepted frame.
// Optional FCS check when ETH_RX_CRC_CHECK_EN is defined.
// Handshake: payload_valid_o is a one-cycle strobe qualifying payload_dat_o;
// there is no backpressure, the consumer must take every strobed byte.
module eth_udp_rx_gmii
  import eth_udp_pkg::*;
#(
  parameter logic [15:0] ETH_type    = ETH_TYPE_DEFAULT,
  parameter logic [7:0]  IP_protocol = IP_PROTO_DEFAULT
) (
  input  logic        clk125m,
  input  logic        reset_p,
  input  logic        gmii_rxdv,
  input  logic [7:0]  gmii_rxd,
  input  logic        gmii_rxer,
  input  logic [47:0] local_mac,
  input  logic [31:0] local_ip,
  input  logic [15:0] local_port,
  output logic        payload_valid_o,
  output logic [7:0]  payload_dat_o,
  output logic [47:0] src_mac,
  output logic [31:0] src_ip,
  output logic [15:0] src_port,
  output logic [15:0] data_length,
  output logic        rx_done,
  output logic        rx_err,
  output logic [7:0]  o_dbg_state
);

  logic        r_rxdv, r_rxdv_d, r_rxer, r_seen_low, r_err_flag;
  logic [7:0]  r_rxd;
  rx_state_t   r_state, w_next;
  logic [15:0] r_cnt;
  logic [47:0] r_mac_dst, r_mac_src;
  logic [7:0]  r_type_hi, r_ip_ver, r_ip_proto;
  logic [31:0] r_ip_src;
  logic [23:0] r_ip_dst;
  logic [15:0] r_udp_src, r_udp_dst, r_udp_len;
  logic        w_start, w_udp_ok, w_pay, w_done, w_err, w_rise, w_fcs_bad;

  // Input register; r_seen_low blocks a false start when reset releases mid-frame.
  always_ff @(posedge clk125m or posedge reset_p) begin
    if (reset_p) begin
      r_rxdv <= 1'b0; r_rxdv_d <= 1'b0; r_rxd <= 8'h00; r_rxer <= 1'b0; r_seen_low <= 1'b0;
    end else begin
      r_rxdv <= gmii_rxdv; r_rxd <= gmii_rxd; r_rxer <= gmii_rxer; r_rxdv_d <= r_rxdv;
      if (!r_rxdv) r_seen_low <= 1'b1;
    end
  end

  assign w_rise      = r_seen_low & ~r_rxdv_d & r_rxdv;
  assign o_dbg_state = r_state;

  // State register.
  always_ff @(posedge clk125m or posedge reset_p) begin
    if (reset_p) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // Next-state and per-cycle event decode; header checks happen on the last header byte.
  always_comb begin
    w_next = r_state; w_start = 1'b0; w_udp_ok = 1'b0; w_pay = 1'b0; w_done = 1'b0; w_err = 1'b0;
    unique case (r_state)
      IDLE: if (w_rise && r_rxd == 8'h55) begin w_next = RX_PREAMBLE; w_start = 1'b1; end
      RX_PREAMBLE:
        if (!r_rxdv)             w_next = IDLE;
        else if (r_rxd == 8'hD5) w_next = RX_ETH_HEADER;
        else if (r_rxd != 8'h55) w_next = RX_DROP;
      RX_ETH_HEADER:
        if (!r_rxdv) w_next = IDLE;
        else if (r_cnt == ETH_HDR_BYTES - 16'd1)
          w_next = ((r_mac_dst == local_mac || r_mac_dst == BCAST_MAC) &&
                    {r_type_hi, r_rxd} == ETH_type) ? RX_IP_HEADER : RX_DROP;
      RX_IP_HEADER:
        if (!r_rxdv) w_next = IDLE;
        else if (r_cnt == IP_HDR_BYTES - 16'd1)
          w_next = (r_ip_ver == 8'h45 && r_ip_proto == IP_protocol &&
                    {r_ip_dst, r_rxd} == local_ip) ? RX_UDP_HEADER : RX_DROP;
      RX_UDP_HEADER:
        if (!r_rxdv) w_next = IDLE;
        else if (r_cnt == UDP_HDR_BYTES - 16'd1) begin
          if (r_udp_dst == local_port && r_udp_len >= 16'd8) begin
            w_udp_ok = 1'b1;
            w_next   = (r_udp_len == 16'd8) ? RX_TAIL : RX_DATA;
          end else begin
            w_next = RX_DROP;
          end
        end
      RX_DATA:
        if (!r_rxdv) begin w_err = 1'b1; w_next = IDLE; end
        else begin
          w_pay = 1'b1;
          if (r_cnt + 16'd1 == data_length) w_next = RX_TAIL;
        end
      RX_TAIL:
        if (!r_rxdv) begin
          w_next = IDLE;
          if (r_err_flag || w_fcs_bad) w_err = 1'b1;
          else                         w_done = 1'b1;
        end
      RX_DROP: if (!r_rxdv) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Byte counter within a state, error flag and header field capture.
  always_ff @(posedge clk125m or posedge reset_p) begin
    if (reset_p) begin
      r_cnt <= '0; r_err_flag <= 1'b0; r_mac_dst <= '0; r_mac_src <= '0; r_type_hi <= '0;
      r_ip_ver <= '0; r_ip_proto <= '0; r_ip_src <= '0; r_ip_dst <= '0;
      r_udp_src <= '0; r_udp_dst <= '0; r_udp_len <= '0;
    end else begin
      if (w_next != r_state) r_cnt <= '0;
      else if (r_rxdv)       r_cnt <= r_cnt + 16'd1;
      if (w_start)                 r_err_flag <= r_rxer;
      else if (r_rxdv && r_rxer)   r_err_flag <= 1'b1;
      if (r_rxdv && r_state == RX_ETH_HEADER) begin
        if (r_cnt < 16'd6)       r_mac_dst <= {r_mac_dst[39:0], r_rxd};
        else if (r_cnt < 16'd12) r_mac_src <= {r_mac_src[39:0], r_rxd};
        else if (r_cnt == 16'd12) r_type_hi <= r_rxd;
      end
      if (r_rxdv && r_state == RX_IP_HEADER) begin
        if (r_cnt == 16'd0)       r_ip_ver   <= r_rxd;
        if (r_cnt == 16'd9)       r_ip_proto <= r_rxd;
        if (r_cnt >= 16'd12 && r_cnt < 16'd16) r_ip_src <= {r_ip_src[23:0], r_rxd};
        if (r_cnt >= 16'd16)      r_ip_dst   <= {r_ip_dst[15:0], r_rxd};
      end
      if (r_rxdv && r_state == RX_UDP_HEADER) begin
        if (r_cnt < 16'd2)       r_udp_src <= {r_udp_src[7:0], r_rxd};
        else if (r_cnt < 16'd4)  r_udp_dst <= {r_udp_dst[7:0], r_rxd};
        else if (r_cnt < 16'd6)  r_udp_len <= {r_udp_len[7:0], r_rxd};
      end
    end
  end

  // Output registers: payload strobe, end-of-frame pulses, sender fields on header accept.
  always_ff @(posedge clk125m or posedge reset_p) begin
    if (reset_p) begin
      payload_valid_o <= 1'b0; payload_dat_o <= '0; rx_done <= 1'b0; rx_err <= 1'b0;
      src_mac <= '0; src_ip <= '0; src_port <= '0; data_length <= '0;
    end else begin
      payload_valid_o <= w_pay;
      if (w_pay) payload_dat_o <= r_rxd;
      rx_done <= w_done;
      rx_err  <= w_err;
      if (w_udp_ok) begin
        src_mac <= r_mac_src; src_ip <= r_ip_src; src_port <= r_udp_src;
        data_length <= r_udp_len - 16'd8;
      end
    end
  end

`ifdef ETH_RX_CRC_CHECK_EN
  // Four-byte delay line: the CRC only sees a byte once four newer ones exist,
  // so at rxdv fall the line holds exactly the FCS.
  logic [7:0]  r_dly [4];
  logic [2:0]  r_fill;
  logic        w_shift;
  logic [31:0] w_crc;

  assign w_shift = r_rxdv && (r_state == RX_ETH_HEADER || r_state == RX_IP_HEADER ||
                              r_state == RX_UDP_HEADER || r_state == RX_DATA || r_state == RX_TAIL);

  // Delay line shift and fill count.
  always_ff @(posedge clk125m or posedge reset_p) begin
    if (reset_p) begin
      r_fill <= '0;
      for (int i = 0; i < 4; i++) r_dly[i] <= '0;
    end else if (w_start) begin
      r_fill <= '0;
    end else if (w_shift) begin
      r_dly[0] <= r_rxd; r_dly[1] <= r_dly[0]; r_dly[2] <= r_dly[1]; r_dly[3] <= r_dly[2];
      if (r_fill != 3'd4) r_fill <= r_fill + 3'd1;
    end
  end

  crc32_d8 u_crc (
    .clk        (clk125m),
    .reset_p    (reset_p),
    .data       (r_dly[3]),
    .crc_init   (w_start),
    .crc_en     (w_shift && r_fill == 3'd4),
    .crc_result (w_crc)
  );

  assign w_fcs_bad = (r_fill != 3'd4) || ({r_dly[0], r_dly[1], r_dly[2], r_dly[3]} != w_crc);
`else
  assign w_fcs_bad = 1'b0;
`endif

endmodule

// File: doc/eth_udp_rx_gmii.md
ETH_UDP_RX_GMII -- requirements
Module: eth_udp_rx_gmii

Interface
REQ-001 Parameter ETH_type, 16'h0800, required EtherType.
REQ-002 Parameter IP_protocol, 8'h11, required IP protocol (UDP).
REQ-003 clk125m  input  1  GMII receive clock, 125 MHz, sole clock.
REQ-004 reset_p  input  1  asynchronous, active-high reset.
REQ-005 gmii_rxdv  input  1  GMII receive data valid.
REQ-006 gmii_rxd  input  8  GMII receive data.
REQ-007 gmii_rxer  input  1  GMII receive error.
REQ-008 local_mac / local_ip / local_port  input  48/32/16  filter addresses, static during a frame.
REQ-009 payload_valid_o  output  1  payload byte strobe.
REQ-010 payload_dat_o  output  8  payload byte.
REQ-011 src_mac / src_ip / src_port  output  48/32/16  sender fields of last accepted frame.
REQ-012 data_length  output  16  payload bytes of last accepted frame (UDP length - 8).
REQ-013 rx_done  output  1  one-cycle pulse, accepted frame ended good.
REQ-014 rx_err  output  1  one-cycle pulse, accepted frame ended bad.

Function
REQ-015 gmii_rxdv/rxd/rxer shall be registered once before use; all decisions use registered copies.
REQ-016 One-hot states: IDLE, RX_PREAMBLE, RX_ETH_HEADER, RX_IP_HEADER, RX_UDP_HEADER, RX_DATA, RX_TAIL, RX_DROP.
REQ-017 IDLE -> RX_PREAMBLE only on rxdv rising (prev low, now high) with byte 8'h55; otherwise stay.
REQ-018 RX_PREAMBLE: 8'h55 stay; 8'hD5 -> RX_ETH_HEADER; any other byte -> RX_DROP.
REQ-019 RX_ETH_HEADER: 14 bytes, MSB first; dst MAC must equal local_mac or 48'hFFFF_FFFF_FFFF, type must equal ETH_type, else -> RX_DROP.
REQ-020 RX_IP_HEADER: 20 bytes; byte0 must be 8'h45, protocol IP_protocol, dst IP equal local_ip, else -> RX_DROP; IP checksum not verified.
REQ-021 RX_UDP_HEADER: 8 bytes; dst port must equal local_port and UDP length >= 8, else -> RX_DROP; UDP checksum ignored.
REQ-022 RX_DATA: UDP length - 8 bytes, each driven on payload_dat_o with payload_valid_o high for one cycle, 2 cycles after the byte's sampling edge; UDP length 8 skips to RX_TAIL.
REQ-023 RX_TAIL: pad bytes and FCS consumed, not output; exit on rxdv low.
REQ-024 RX_DROP: no outputs; -> IDLE on rxdv low; no rx_done/rx_err.
REQ-025 FCS: bytes after SFD pass a 4-byte delay line into the CRC; at rxdv fall the 4 held bytes are the FCS, compared LSB-byte first against crc_result[7:0],[15:8],[23:16],[31:24].
REQ-026 Frame end after UDP header accepted: exactly one of rx_done/rx_err, 2 cycles after rxdv sampled low.
REQ-027 rx_err when: FCS mismatch, rxer high on any byte of the frame, or rxdv low before all payload bytes received (truncation; payload_valid_o stops immediately).
REQ-028 rxdv low in PREAMBLE or any header state: -> IDLE silently.
REQ-029 src_mac/src_ip/src_port/data_length update at UDP header completion; hold otherwise.
REQ-030 Counters are 16-bit; payload counter compares against UDP length - 8 without wrap.

Reset
REQ-031 reset_p forces IDLE, all outputs and registers 0, CRC re-initialised; asserted mid-frame no pulse is emitted and the remainder of that frame is ignored (needs rxdv rising).
REQ-032 CRC initialised on every IDLE -> RX_PREAMBLE transition.

Configuration
REQ-033 ETH_RX_CRC_CHECK_EN defined: REQ-025 check active, mismatch -> rx_err.
REQ-034 ETH_RX_CRC_CHECK_EN undefined: no CRC instance or delay line; FCS bytes ignored; rx_err only for rxer/truncation.

Structure
REQ-035 Package eth_udp_pkg: state encodings, header byte counts (14/20/8), ETH_type/IP_protocol defaults, broadcast MAC constant.
REQ-036 One sub-module: existing crc32_d8 (clk, reset_p, data, crc_init, crc_en, crc_result), instantiated only under ETH_RX_CRC_CHECK_EN.

Verification
REQ-037 Valid frame to 192.168.0.2:5000, 4-byte payload 01 02 03 04, good FCS -> 4 strobes 01..04, data_length 4, rx_done once, rx_err 0.
REQ-038 Same frame, last FCS byte XOR 8'h01 -> same payload, rx_err once, rx_done 0 (macro undefined: rx_done).
REQ-039 dst port 5001 with local_port 5000 -> no strobes, no pulses; next valid frame accepted normally.
REQ-040 Broadcast MAC, 1-byte payload AA, 17 pad bytes -> 1 strobe AA, pad not output, rx_done.
REQ-041 rxdv dropped after 2 of 10 payload bytes -> 2 strobes, rx_err once.
REQ-042 reset_p pulsed mid-payload -> outputs 0 immediately, no pulse, following frame after rxdv low accepted.
